// File: rtl/block_bist.sv
// ----------------------------------------------------------------------------
// block_bist
// Built-in pattern source and response compactor for the `block` timing-test
// cell. A 16-bit LFSR drives the block inputs. A 16-bit MISR folds the block
// outputs into a signature, which is then compared against EXP_SIG.
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   start      run request, sampled on the rising edge
//   resp1/2    block out1/out2, fed into the MISR
//   drv1/2/3   block in1/in2/in3, driven from lfsr[0]/[1]/[2]
//   busy       high while a run is in progress
//   done       sticky run-complete flag
//   pass       final signature equals EXP_SIG (valid while done = 1)
//   signature  current MISR value
// ----------------------------------------------------------------------------
module block_bist #(
    parameter int unsigned PAT_LEN = 64,
    parameter int unsigned LAT     = 2,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter logic [15:0] EXP_SIG = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        resp1,
    input  logic        resp2,
    output logic        drv1,
    output logic        drv2,
    output logic        drv3,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    // A run lasts PAT_LEN + LAT cycles. The sum needs 17 bits so that the
    // counter can hold it without wrapping.
    localparam logic [16:0] C_LAST   = 17'(PAT_LEN + LAT - 1);
    localparam logic [16:0] C_PAT    = 17'(PAT_LEN);
    localparam logic [16:0] C_LAT    = 17'(LAT);
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] LOAD_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_lfsr;
    logic [15:0] r_misr;
    logic [16:0] r_c;
    logic        r_done;
    logic        r_pass;

    logic        w_load;
    logic        w_finish;
    logic        w_lastCycle;
    logic        w_inPattern;
    logic        w_compact;
    logic        w_lfsrFb;
    logic        w_misrFb;
    logic [15:0] w_lfsrNext;
    logic [15:0] w_misrNext;
    logic        w_drvEn;

    assign w_lastCycle = (r_c == C_LAST);
    assign w_inPattern = (r_c < C_PAT);
    // The first LAT response cycles hold nothing from this run, so they are skipped.
    assign w_compact   = (r_c >= C_LAT);

    // Polynomial x^16+x^14+x^13+x^11+1, shared by the LFSR and the MISR.
    assign w_lfsrFb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsrNext = {r_lfsr[14:0], w_lfsrFb};
    assign w_misrFb   = r_misr[15] ^ r_misr[13] ^ r_misr[12] ^ r_misr[10];
    assign w_misrNext = {r_misr[14:0], w_misrFb} ^ {14'b0, resp2, resp1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // start is honoured only in IDLE and DONE. A run that is in progress
    // cannot be restarted.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = RUN;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (w_lastCycle) begin
                    w_nextState = DONE;
                    w_finish    = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    w_nextState = RUN;
                    w_load      = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The counter keeps incrementing on the final edge and then holds at
    // PAT_LEN+LAT while in DONE. PAT_LEN >= 1, so the final cycle always
    // compacts, and pass can be judged on w_misrNext directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'h0000;
            r_misr <= 16'h0000;
            r_c    <= 17'd0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_load) begin
            r_lfsr <= LOAD_VAL;
            r_misr <= 16'h0000;
            r_c    <= 17'd0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (r_state == RUN) begin
            if (w_inPattern) begin
                r_lfsr <= w_lfsrNext;
            end
            if (w_compact) begin
                r_misr <= w_misrNext;
            end
            r_c <= r_c + 17'd1;
            if (w_finish) begin
                r_done <= 1'b1;
                r_pass <= (w_misrNext == EXP_SIG);
            end
        end
    end

    // The drive outputs depend only on registered state, so there is no path
    // from resp or start to any output. They are zero during the flush cycles.
    assign busy      = (r_state == RUN);
    assign w_drvEn   = busy & w_inPattern;
    assign drv1      = w_drvEn & r_lfsr[0];
    assign drv2      = w_drvEn & r_lfsr[1];
    assign drv3      = w_drvEn & r_lfsr[2];
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = r_misr;

endmodule

// File: tb/tb_block_bist.sv
// ----------------------------------------------------------------------------
// tb_block_bist
// Directed bench for block_bist. Four instances with different parameters
// share one clock and reset:
//   A  SEED=1, PAT_LEN=4, LAT=0     pattern order, back-to-back runs
//   B  PAT_LEN=2, LAT=0, EXP_SIG=3  MISR arithmetic, restart from DONE
//   C  PAT_LEN=4, LAT=2, EXP_SIG=0  latency skip, flush, start ignored in RUN
//   D  defaults, closed loop through a two-stage model of block
// ----------------------------------------------------------------------------
module tb_block_bist;

    // Golden signature for instance D. It models a closed loop with the
    // default seed, 64 patterns and a 2-cycle block whose outputs are
    // out1 = in1^in3 and out2 = in2.
    function automatic logic [15:0] goldenSig();
        logic [15:0] l;
        logic [15:0] m;
        logic [1:0]  p1;
        logic [1:0]  p2;
        logic [2:0]  d;
        l  = 16'hACE1;
        m  = 16'h0000;
        p1 = 2'b00;
        p2 = 2'b00;
        for (int c = 0; c < 66; c++) begin
            d = (c < 64) ? l[2:0] : 3'b000;
            if (c >= 2) begin
                m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {14'b0, p2};
            end
            p2 = p1;
            p1 = {d[1], d[0] ^ d[2]};
            if (c < 64) begin
                l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            end
        end
        return m;
    endfunction

    localparam logic [15:0] GOLDEN_SIG = goldenSig();

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic startA, startB, startC, startD;
    logic respB1, respB2, respC1, respC2;
    logic respD1, respD2;

    logic drvA1, drvA2, drvA3, busyA, doneA, passA;
    logic drvB1, drvB2, drvB3, busyB, doneB, passB;
    logic drvC1, drvC2, drvC3, busyC, doneC, passC;
    logic drvD1, drvD2, drvD3, busyD, doneD, passD;
    logic [15:0] sigA, sigB, sigC, sigD;

    int testCount = 0;
    int failCount = 0;
    int busyCount;

    logic [2:0] expPat [0:4];
    logic       expBusy [0:5];
    logic       expDone [0:5];

    block_bist #(.PAT_LEN(4), .LAT(0), .SEED(16'h0001), .EXP_SIG(16'h0000)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .resp1(1'b0), .resp2(1'b0),
        .drv1(drvA1), .drv2(drvA2), .drv3(drvA3), .busy(busyA), .done(doneA),
        .pass(passA), .signature(sigA)
    );

    block_bist #(.PAT_LEN(2), .LAT(0), .SEED(16'hACE1), .EXP_SIG(16'h0003)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .resp1(respB1), .resp2(respB2),
        .drv1(drvB1), .drv2(drvB2), .drv3(drvB3), .busy(busyB), .done(doneB),
        .pass(passB), .signature(sigB)
    );

    block_bist #(.PAT_LEN(4), .LAT(2), .SEED(16'hACE1), .EXP_SIG(16'h0000)) dutC (
        .clk(clk), .rst_n(rst_n), .start(startC), .resp1(respC1), .resp2(respC2),
        .drv1(drvC1), .drv2(drvC2), .drv3(drvC3), .busy(busyC), .done(doneC),
        .pass(passC), .signature(sigC)
    );

    block_bist #(.PAT_LEN(64), .LAT(2), .SEED(16'hACE1), .EXP_SIG(GOLDEN_SIG)) dutD (
        .clk(clk), .rst_n(rst_n), .start(startD), .resp1(respD1), .resp2(respD2),
        .drv1(drvD1), .drv2(drvD2), .drv3(drvD3), .busy(busyD), .done(doneD),
        .pass(passD), .signature(sigD)
    );

    // Stand-in for block: two register stages, out1 = in1^in3, out2 = in2.
    logic [1:0] blkStage1, blkStage2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blkStage1 <= 2'b00;
            blkStage2 <= 2'b00;
        end else begin
            blkStage1 <= {drvD2, drvD1 ^ drvD3};
            blkStage2 <= blkStage1;
        end
    end
    assign respD1 = blkStage2[0];
    assign respD2 = blkStage2[1];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(output logic sig, input logic val);
        sig = val;
    endtask

    initial begin
        rst_n  = 1'b0;
        startA = 1'b0; startB = 1'b0; startC = 1'b0; startD = 1'b0;
        respB1 = 1'b1; respB2 = 1'b0;
        respC1 = 1'b0; respC2 = 1'b0;
        expPat[0] = 3'b001; expPat[1] = 3'b010; expPat[2] = 3'b100;
        expPat[3] = 3'b000; expPat[4] = 3'b000;
        expBusy[0] = 1; expBusy[1] = 1; expBusy[2] = 1; expBusy[3] = 1;
        expBusy[4] = 0; expBusy[5] = 1;
        expDone[0] = 0; expDone[1] = 0; expDone[2] = 0; expDone[3] = 0;
        expDone[4] = 1; expDone[5] = 0;

        // Reset state
        #12;
        checkOutput("rst_busyA", 32'(busyA), 32'd0);
        checkOutput("rst_doneA", 32'(doneA), 32'd0);
        checkOutput("rst_passA", 32'(passA), 32'd0);
        checkOutput("rst_sigA", 32'(sigA), 32'h0);
        checkOutput("rst_drvD", 32'({drvD3, drvD2, drvD1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Pattern order on A
        applyStimulus(startA, 1'b1);
        tick();
        applyStimulus(startA, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("A_pat%0d", i), 32'({drvA3, drvA2, drvA1}), 32'(expPat[i]));
            checkOutput($sformatf("A_busy%0d", i), 32'(busyA), (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        checkOutput("A_done", 32'(doneA), 32'd1);

        // Back-to-back runs with start held high on A
        applyStimulus(startA, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("A_b2b_busy%0d", i), 32'(busyA), 32'(expBusy[i]));
            checkOutput($sformatf("A_b2b_done%0d", i), 32'(doneA), 32'(expDone[i]));
        end
        applyStimulus(startA, 1'b0);

        // MISR arithmetic on B
        applyStimulus(startB, 1'b1);
        tick();
        applyStimulus(startB, 1'b0);
        checkOutput("B_sig0", 32'(sigB), 32'h0000);
        tick();
        checkOutput("B_sig1", 32'(sigB), 32'h0001);
        checkOutput("B_busy1", 32'(busyB), 32'd1);
        tick();
        checkOutput("B_sig2", 32'(sigB), 32'h0003);
        checkOutput("B_done", 32'(doneB), 32'd1);
        checkOutput("B_pass", 32'(passB), 32'd1);
        checkOutput("B_busyEnd", 32'(busyB), 32'd0);

        // Restart B from DONE: done/pass/MISR clear on the start edge
        tick();
        applyStimulus(startB, 1'b1);
        tick();
        applyStimulus(startB, 1'b0);
        checkOutput("B_re_busy", 32'(busyB), 32'd1);
        checkOutput("B_re_done", 32'(doneB), 32'd0);
        checkOutput("B_re_pass", 32'(passB), 32'd0);
        checkOutput("B_re_sig", 32'(sigB), 32'h0000);
        tick();
        tick();
        checkOutput("B_re_sigEnd", 32'(sigB), 32'h0003);
        checkOutput("B_re_passEnd", 32'(passB), 32'd1);

        // Latency skip, flush and start ignored during RUN on C
        applyStimulus(startC, 1'b1);
        tick();
        applyStimulus(startC, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("C_busy%0d", i), 32'(busyC), 32'd1);
            if (i >= 4) begin
                checkOutput($sformatf("C_flush%0d", i), 32'({drvC3, drvC2, drvC1}), 32'd0);
            end
            applyStimulus(startC, (i == 2) ? 1'b1 : 1'b0);
            tick();
        end
        applyStimulus(startC, 1'b0);
        checkOutput("C_busyEnd", 32'(busyC), 32'd0);
        checkOutput("C_done", 32'(doneC), 32'd1);
        checkOutput("C_sig", 32'(sigC), 32'h0000);
        checkOutput("C_pass", 32'(passC), 32'd1);

        // Reset in the middle of a run on D (c = 10)
        applyStimulus(startD, 1'b1);
        tick();
        applyStimulus(startD, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        checkOutput("D_midBusy", 32'(busyD), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("D_rstBusy", 32'(busyD), 32'd0);
        checkOutput("D_rstDone", 32'(doneD), 32'd0);
        checkOutput("D_rstDrv", 32'({drvD3, drvD2, drvD1}), 32'd0);
        checkOutput("D_rstSig", 32'(sigD), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("D_idleDone", 32'(doneD), 32'd0);
        checkOutput("D_idleBusy", 32'(busyD), 32'd0);

        // Closed loop through the block model on D
        applyStimulus(startD, 1'b1);
        tick();
        applyStimulus(startD, 1'b0);
        busyCount = 0;
        for (int i = 0; i < 200 && !doneD; i++) begin
            if (busyD) busyCount++;
            tick();
        end
        checkOutput("D_doneReached", 32'(doneD), 32'd1);
        checkOutput("D_busyCycles", 32'(busyCount), 32'd66);
        checkOutput("D_sig", 32'(sigD), 32'(GOLDEN_SIG));
        checkOutput("D_pass", 32'(passD), 32'd1);
        checkOutput("D_drvIdle", 32'({drvD3, drvD2, drvD1}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
